// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control encodings: opcode/func3 fields, FSM states and datapath select codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_HALT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
        S_EXECR, S_EXECI, S_EXECA, S_EXECL, S_ALUWB, S_BRANCH, S_JALRADR, S_JUMP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    function automatic logic alu_i_ok(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_SLL) || (f3 == F3_SLT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, mux selects and strobes out.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;

    modport master (
        input  opcode, func3, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src
    );
    modport slave (
        output opcode, func3, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// State -> control-vector decode for the multicycle controller.
// Latency: combinational. Backpressure: FETCH strobes qualify on mem_ready.
module mc_ctrl_outdec
    import riscv_ctrl_pkg::*;
(
    input  state_t     st,
    input  logic       mem_ready,
    input  logic       zero,
    input  logic [2:0] func3,
    output ctrl_t      ctl
);

    always_comb begin
        ctl = '0;
        case (st)
            S_FETCH: begin
                ctl.mem_req    = 1'b1;
                ctl.alu_src_a  = SRCA_PC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALU;
                ctl.ir_write   = mem_ready;
                ctl.pc_write   = mem_ready;
            end
            S_DECODE, S_EXECA: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALRADR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl.mem_req = 1'b1;
                ctl.adr_src = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = 1'b1;
                ctl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.result_src = RES_MEM;
            end
            S_EXECR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_RS2;
                ctl.alu_op    = ALUOP_FUNC;
            end
            S_EXECI: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_FUNC;
            end
            S_EXECL: begin
                ctl.alu_src_a = SRCA_ZERO;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                ctl.reg_write  = 1'b1;
                ctl.result_src = RES_ALUOUT;
            end
            S_BRANCH: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_RS2;
                ctl.alu_op    = ALUOP_SUB;
                ctl.pc_src    = 1'b1;
                // beq takes on equal, bne on not-equal
                ctl.pc_write  = (func3 == F3_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                ctl.alu_src_a  = SRCA_OLDPC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALU;
                ctl.reg_write  = 1'b1;
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing ALU, unified memory port and regfile.
// Latency (0-wait mem): lw 5, sw/R/I/AUIPC/LUI/jalr 4, branch/jal 3 cycles.
// Backpressure: memory states hold their request until mem_ready or timeout halt.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int MEM_TMO = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    multicycle_ctrl_if.master  dp,
    output logic               halted,
    output logic               err,
    output logic [CNT_W-1:0]   instret
);

    localparam int TW = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;

    state_t        st, st_nxt;
    ctrl_t         ctl;
    logic [TW-1:0] tmo_ctr;
    logic          mem_wait, tmo_hit, retire, illegal;

    mc_ctrl_outdec u_outdec (
        .st        (st),
        .mem_ready (dp.mem_ready),
        .zero      (dp.zero),
        .func3     (dp.func3),
        .ctl       (ctl)
    );

    assign dp.mem_req    = ctl.mem_req;
    assign dp.mem_we     = ctl.mem_we;
    assign dp.adr_src    = ctl.adr_src;
    assign dp.ir_write   = ctl.ir_write;
    assign dp.pc_write   = ctl.pc_write;
    assign dp.pc_src     = ctl.pc_src;
    assign dp.reg_write  = ctl.reg_write;
    assign dp.alu_src_a  = ctl.alu_src_a;
    assign dp.alu_src_b  = ctl.alu_src_b;
    assign dp.alu_op     = ctl.alu_op;
    assign dp.result_src = ctl.result_src;
    assign halted        = (st == S_HALT);

    assign mem_wait = ctl.mem_req && !dp.mem_ready;
    assign tmo_hit  = (MEM_TMO != 0) && mem_wait && (tmo_ctr == TW'(MEM_TMO - 1));

    always_comb begin
        st_nxt  = st;
        retire  = 1'b0;
        illegal = 1'b0;
        case (st)
            S_HALT:   if (run && !err) st_nxt = S_FETCH;
            S_FETCH:  if (tmo_hit) st_nxt = S_HALT;
                      else if (dp.mem_ready) st_nxt = S_DECODE;
            S_DECODE: begin
                case (dp.opcode)
                    OP_LOAD, OP_STORE: st_nxt = S_MEMADR;
                    OP_R:     st_nxt = S_EXECR;
                    OP_I:     if (alu_i_ok(dp.func3)) st_nxt = S_EXECI; else illegal = 1'b1;
                    OP_AUIPC: st_nxt = S_EXECA;
                    OP_LUI:   st_nxt = S_EXECL;
                    OP_B:     if (dp.func3 == F3_BEQ || dp.func3 == F3_BNE) st_nxt = S_BRANCH;
                              else illegal = 1'b1;
                    OP_JAL:   st_nxt = S_JUMP;
                    OP_JALR:  st_nxt = S_JALRADR;
                    default:  illegal = 1'b1;
                endcase
                if (illegal) st_nxt = S_HALT;
            end
            S_MEMADR: st_nxt = (dp.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (tmo_hit) st_nxt = S_HALT;
                      else if (dp.mem_ready) st_nxt = S_MEMWB;
            S_MEMWR:  if (tmo_hit) st_nxt = S_HALT;
                      else if (dp.mem_ready) retire = 1'b1;
            S_EXECR, S_EXECI, S_EXECA, S_EXECL: st_nxt = S_ALUWB;
            S_JALRADR: st_nxt = S_JUMP;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: retire = 1'b1;
            default:  st_nxt = S_HALT;
        endcase
        // run is only sampled at instruction boundaries
        if (retire) st_nxt = run ? S_FETCH : S_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_HALT;
            err     <= 1'b0;
            instret <= '0;
            tmo_ctr <= '0;
        end else begin
            st <= st_nxt;
            if (illegal || tmo_hit) err <= 1'b1;
            if (retire) instret <= instret + CNT_W'(1);
            if (!mem_wait || tmo_hit) tmo_ctr <= '0;
            else                      tmo_ctr <= tmo_ctr + TW'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with CNT_W=4, MEM_TMO=4; per-state control vectors hand-derived.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       halted, err;
    logic [3:0] instret;
    int         n_pass = 0;
    int         n_total = 0;

    multicycle_ctrl_if dp();

    multicycle_ctrl #(.CNT_W(4), .MEM_TMO(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .dp      (dp.master),
        .halted  (halted),
        .err     (err),
        .instret (instret)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,adr_src,ir_write,pc_write,pc_src,reg_write, a, b, op, res}
    localparam logic [14:0] V_HALT    = 15'b0;
    localparam logic [14:0] V_FETCH_W = {7'b1000000, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam logic [14:0] V_FETCH_R = {7'b1001100, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam logic [14:0] V_DECODE  = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] V_MEMADR  = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] V_MEMRD   = {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] V_MEMWR   = {7'b1110000, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] V_MEMWB   = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b01};
    localparam logic [14:0] V_EXECI   = {7'b0000000, 2'b10, 2'b01, 2'b10, 2'b00};
    localparam logic [14:0] V_ALUWB   = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] V_BR_T    = {7'b0000110, 2'b10, 2'b00, 2'b01, 2'b00};
    localparam logic [14:0] V_BR_N    = {7'b0000010, 2'b10, 2'b00, 2'b01, 2'b00};
    localparam logic [14:0] V_JALRADR = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] V_JUMP    = {7'b0000111, 2'b01, 2'b10, 2'b00, 2'b10};

    function automatic logic [14:0] act();
        return {dp.mem_req, dp.mem_we, dp.adr_src, dp.ir_write, dp.pc_write, dp.pc_src,
                dp.reg_write, dp.alu_src_a, dp.alu_src_b, dp.alu_op, dp.result_src};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        dp.opcode = 7'd0; dp.func3 = 3'd0; dp.zero = 1'b0; dp.mem_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Issues one 0-wait jal starting from FETCH; returns in the next FETCH.
    task automatic do_jal();
        dp.opcode = OP_JAL; dp.mem_ready = 1'b1;
        step();
        dp.mem_ready = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1;
        dp.opcode = 7'd0; dp.func3 = 3'd0; dp.zero = 1'b0; dp.mem_ready = 1'b0;
        #1;
        n_total++; if ({halted, err, instret, act()} !== {1'b1, 1'b0, 4'd0, V_HALT})
            $display("FAIL reset_state got %b want %b", {halted, err, instret, act()}, {1'b1, 1'b0, 4'd0, V_HALT}); else n_pass++;
        step(); rst_n = 1'b1; step();
        dp.opcode = OP_I; dp.func3 = 3'b000; dp.mem_ready = 1'b1; #1;
        n_total++; if (act() !== V_FETCH_R) $display("FAIL addi_fetch got %b want %b", act(), V_FETCH_R); else n_pass++;
        step(); dp.mem_ready = 1'b0; #1;
        n_total++; if (act() !== V_DECODE) $display("FAIL addi_decode got %b want %b", act(), V_DECODE); else n_pass++;
        step(); #1;
        n_total++; if (act() !== V_EXECI) $display("FAIL addi_execi got %b want %b", act(), V_EXECI); else n_pass++;
        step(); #1;
        n_total++; if ({act(), instret} !== {V_ALUWB, 4'd0}) $display("FAIL addi_aluwb got %b want %b", {act(), instret}, {V_ALUWB, 4'd0}); else n_pass++;
        step(); #1;
        n_total++; if ({act(), instret} !== {V_FETCH_W, 4'd1}) $display("FAIL addi_retire got %b want %b", {act(), instret}, {V_FETCH_W, 4'd1}); else n_pass++;
        dp.opcode = 7'd0; dp.mem_ready = 1'b1;
        step(); dp.mem_ready = 1'b0;
        step(); #1;
        n_total++; if ({halted, err, instret, act()} !== {1'b1, 1'b1, 4'd1, V_HALT})
            $display("FAIL illegal_halt got %b want %b", {halted, err, instret, act()}, {1'b1, 1'b1, 4'd1, V_HALT}); else n_pass++;
        step(); step(); #1;
        n_total++; if ({halted, err} !== 2'b11) $display("FAIL err_sticky got %b want 11", {halted, err}); else n_pass++;
    endtask

    task automatic test_lw_wait();
        do_reset(); run = 1'b1; step();
        dp.opcode = OP_LOAD; dp.func3 = 3'b010; dp.mem_ready = 1'b1;
        step();
        #1;
        n_total++; if (act() !== V_DECODE) $display("FAIL lw_decode_ready_ignored got %b want %b", act(), V_DECODE); else n_pass++;
        step(); dp.mem_ready = 1'b0; #1;
        n_total++; if (act() !== V_MEMADR) $display("FAIL lw_memadr got %b want %b", act(), V_MEMADR); else n_pass++;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (act() !== V_MEMRD) $display("FAIL lw_memrd_wait%0d got %b want %b", i, act(), V_MEMRD); else n_pass++;
            step();
        end
        dp.mem_ready = 1'b1; #1;
        n_total++; if ({act(), halted} !== {V_MEMRD, 1'b0}) $display("FAIL lw_memrd_ready got %b want %b", {act(), halted}, {V_MEMRD, 1'b0}); else n_pass++;
        step(); dp.mem_ready = 1'b0; #1;
        n_total++; if (act() !== V_MEMWB) $display("FAIL lw_memwb got %b want %b", act(), V_MEMWB); else n_pass++;
        step(); #1;
        n_total++; if ({act(), instret, err} !== {V_FETCH_W, 4'd1, 1'b0}) $display("FAIL lw_retire got %b want %b", {act(), instret, err}, {V_FETCH_W, 4'd1, 1'b0}); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset(); run = 1'b1; step();
        dp.opcode = OP_B; dp.func3 = F3_BEQ; dp.mem_ready = 1'b1;
        step(); dp.mem_ready = 1'b0;
        step(); dp.zero = 1'b1; #1;
        n_total++; if (act() !== V_BR_T) $display("FAIL beq_taken got %b want %b", act(), V_BR_T); else n_pass++;
        step();
        dp.func3 = F3_BNE; dp.mem_ready = 1'b1;
        step(); dp.mem_ready = 1'b0;
        step(); #1;
        n_total++; if (act() !== V_BR_N) $display("FAIL bne_not_taken got %b want %b", act(), V_BR_N); else n_pass++;
        dp.zero = 1'b0; #1;
        n_total++; if (act() !== V_BR_T) $display("FAIL bne_taken got %b want %b", act(), V_BR_T); else n_pass++;
        step(); #1;
        n_total++; if ({act(), instret} !== {V_FETCH_W, 4'd2}) $display("FAIL branch_retire got %b want %b", {act(), instret}, {V_FETCH_W, 4'd2}); else n_pass++;
    endtask

    task automatic test_jalr();
        do_reset(); run = 1'b1; step();
        dp.opcode = OP_JALR; dp.func3 = 3'b000; dp.mem_ready = 1'b1;
        step(); dp.mem_ready = 1'b0;
        step(); #1;
        n_total++; if (act() !== V_JALRADR) $display("FAIL jalr_adr got %b want %b", act(), V_JALRADR); else n_pass++;
        step(); #1;
        n_total++; if (act() !== V_JUMP) $display("FAIL jalr_jump got %b want %b", act(), V_JUMP); else n_pass++;
        step(); #1;
        n_total++; if ({act(), instret} !== {V_FETCH_W, 4'd1}) $display("FAIL jalr_retire got %b want %b", {act(), instret}, {V_FETCH_W, 4'd1}); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset(); run = 1'b1; step();
        dp.opcode = OP_I; dp.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if ({act(), halted} !== {V_FETCH_W, 1'b0}) $display("FAIL tmo_req%0d got %b want %b", i, {act(), halted}, {V_FETCH_W, 1'b0}); else n_pass++;
            step();
        end
        #1;
        n_total++; if ({halted, err, act()} !== {1'b1, 1'b1, V_HALT}) $display("FAIL tmo_halt got %b want %b", {halted, err, act()}, {1'b1, 1'b1, V_HALT}); else n_pass++;
        step(); step(); step(); #1;
        n_total++; if ({halted, err} !== 2'b11) $display("FAIL tmo_run_ignored got %b want 11", {halted, err}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset(); run = 1'b1; step();
        for (int i = 0; i < 15; i++) do_jal();
        #1;
        n_total++; if (instret !== 4'd15) $display("FAIL count15 got %0d want 15", instret); else n_pass++;
        dp.opcode = OP_STORE; dp.func3 = 3'b010; dp.mem_ready = 1'b1;
        step(); dp.mem_ready = 1'b0;
        step(); step(); #1;
        n_total++; if (act() !== V_MEMWR) $display("FAIL sw_memwr_wait got %b want %b", act(), V_MEMWR); else n_pass++;
        #2; rst_n = 1'b0; #1;
        n_total++; if ({halted, instret, act()} !== {1'b1, 4'd0, V_HALT}) $display("FAIL async_reset got %b want %b", {halted, instret, act()}, {1'b1, 4'd0, V_HALT}); else n_pass++;
        step(); rst_n = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                #1;
                n_total++; if (instret !== 4'd15) $display("FAIL wrap_pre got %0d want 15", instret); else n_pass++;
            end
            do_jal();
        end
        #1;
        n_total++; if ({instret, act()} !== {4'd0, V_FETCH_W}) $display("FAIL wrap_zero got %b want %b", {instret, act()}, {4'd0, V_FETCH_W}); else n_pass++;
        dp.opcode = OP_STORE; dp.mem_ready = 1'b1;
        step(); dp.mem_ready = 1'b0;
        step(); step();
        dp.mem_ready = 1'b1; run = 1'b0; #1;
        n_total++; if (act() !== V_MEMWR) $display("FAIL sw_memwr_ready got %b want %b", act(), V_MEMWR); else n_pass++;
        step(); dp.mem_ready = 1'b0; #1;
        n_total++; if ({halted, err, instret} !== {1'b1, 1'b0, 4'd1}) $display("FAIL sw_stop_halt got %b want %b", {halted, err, instret}, {1'b1, 1'b0, 4'd1}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw_wait();
        test_branch();
        test_jalr();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
